// File: rtl/pcs_pkg.sv
// Shared constants and types for the 10GBASE-R transmit PCS: XGMII control
// characters, 64b/66b block types, sync headers and scrambler taps.
package pcs_pkg;

    localparam logic [7:0] XGMII_IDLE  = 8'h07;
    localparam logic [7:0] XGMII_START = 8'hFB;
    localparam logic [7:0] XGMII_TERM  = 8'hFD;
    localparam logic [7:0] XGMII_ERROR = 8'hFE;

    localparam logic [7:0] BT_IDLE   = 8'h1E;
    localparam logic [7:0] BT_START0 = 8'h78;
    localparam logic [7:0] BT_START4 = 8'h33;

    localparam logic [6:0] CC_IDLE  = 7'h00;
    localparam logic [6:0] CC_ERROR = 7'h1E;

    localparam logic [1:0] SYNC_DATA = 2'b01;
    localparam logic [1:0] SYNC_CTRL = 2'b10;

    // x^58 + x^39 + 1 expressed as state indices (s[0] is the newest bit)
    localparam int SCR_TAP_A = 38;
    localparam int SCR_TAP_B = 57;

    typedef enum logic {
        OUT_FRAME,
        IN_FRAME
    } frame_state_t;

    typedef enum logic [2:0] {
        BLK_DATA,
        BLK_IDLE,
        BLK_START,
        BLK_TERM,
        BLK_ERROR
    } blk_kind_t;

    function automatic logic [7:0] term_type(input logic [2:0] lane);
        case (lane)
            3'd0:    return 8'h87;
            3'd1:    return 8'h99;
            3'd2:    return 8'hAA;
            3'd3:    return 8'hB4;
            3'd4:    return 8'hCC;
            3'd5:    return 8'hD2;
            3'd6:    return 8'hE1;
            default: return 8'hFF;
        endcase
    endfunction

    function automatic logic [63:0] err_payload();
        logic [63:0] p;
        p = {56'h0, BT_IDLE};
        for (int i = 0; i < 8; i++)
            p[8 + 7*i +: 7] = CC_ERROR;
        return p;
    endfunction

    localparam logic [63:0] ERR_PAYLOAD = err_payload();

endpackage

// File: rtl/pcs_scrambler.sv
// 64-bit parallel self-synchronous scrambler (x^58 + x^39 + 1); the state
// advances only when enable is high.
module pcs_scrambler
    import pcs_pkg::*;
#(
    parameter logic [57:0] SCRAMBLER_SEED = 58'h3FF_FFFF_FFFF_FFFF
) (
    input  logic        tx_clk,
    input  logic        tx_rst,
    input  logic        enable,
    input  logic [63:0] plain,
    output logic [63:0] scrambled
);

    logic [57:0] scr_state;
    logic [57:0] scr_state_next;

    // Bit 0 goes on the wire first, so it is scrambled first
    always_comb begin
        logic [57:0] s;
        s         = scr_state;
        scrambled = '0;
        for (int i = 0; i < 64; i++) begin
            scrambled[i] = plain[i] ^ s[SCR_TAP_A] ^ s[SCR_TAP_B];
            s            = {s[56:0], scrambled[i]};
        end
        scr_state_next = s;
    end

    always_ff @(posedge tx_clk) begin
        if (!tx_rst)
            scr_state <= SCRAMBLER_SEED;
        else if (enable)
            scr_state <= scr_state_next;
    end

endmodule

// File: rtl/tx_pcs_encoder.sv
// 10GBASE-R transmit PCS: pairs 32-bit XGMII words into 64-bit blocks,
// 64b/66b-encodes them under frame-state policing and scrambles the payload.
module tx_pcs_encoder
    import pcs_pkg::*;
#(
    parameter bit          SCRAMBLER_BYPASS = 1'b0,
    parameter logic [57:0] SCRAMBLER_SEED   = 58'h3FF_FFFF_FFFF_FFFF
) (
    input  logic        tx_clk,
    input  logic        tx_rst,
    input  logic [31:0] in_xgmii_data,
    input  logic [3:0]  in_xgmii_ctl,
    input  logic        in_xgmii_valid,
    output logic        out_xgmii_pcs_ready,
    output logic [63:0] out_pcs_data,
    output logic [1:0]  out_pcs_header,
    output logic        out_pcs_valid,
    input  logic        in_pcs_ready,
    output logic        out_encode_error
);

    logic         word_phase;
    logic         load;
    logic [31:0]  word_data;
    logic [3:0]   word_ctl;
    logic [31:0]  lo_data_p0;
    logic [3:0]   lo_ctl_p0;
    logic [63:0]  blk_data;
    logic [7:0]   blk_ctl;
    logic [7:0]   idle_lane;
    logic [7:0]   err_lane;
    logic [7:0]   term_hit;
    logic [2:0]   t_lane;
    logic         start_hi;
    blk_kind_t    kind;
    blk_kind_t    emit;
    frame_state_t state;
    frame_state_t next_state;
    logic [1:0]   enc_header;
    logic [63:0]  enc_payload;
    logic [63:0]  scr_payload;
    logic [63:0]  tx_payload;
    logic [63:0]  term_mask;

    assign out_xgmii_pcs_ready = !out_pcs_valid || in_pcs_ready;
    assign load                = out_xgmii_pcs_ready && word_phase;

    // An absent word is treated as a full idle column
    assign word_data = in_xgmii_valid ? in_xgmii_data : {4{XGMII_IDLE}};
    assign word_ctl  = in_xgmii_valid ? in_xgmii_ctl  : 4'hF;

    // Stage p0: hold the phase-0 word until its partner arrives
    always_ff @(posedge tx_clk) begin
        if (out_xgmii_pcs_ready && !word_phase) begin
            lo_data_p0 <= word_data;
            lo_ctl_p0  <= word_ctl;
        end
    end

    assign blk_data = {word_data, lo_data_p0};
    assign blk_ctl  = {word_ctl, lo_ctl_p0};

    always_comb begin
        idle_lane = '0;
        err_lane  = '0;
        term_hit  = '0;
        kind      = BLK_ERROR;
        t_lane    = 3'd0;
        start_hi  = 1'b0;
        for (int i = 0; i < 8; i++) begin
            idle_lane[i] = blk_ctl[i] && (blk_data[8*i +: 8] == XGMII_IDLE);
            err_lane[i]  = blk_ctl[i] && (blk_data[8*i +: 8] == XGMII_ERROR);
        end
        // /T/ in lane k: data below it, idles above it
        for (int k = 0; k < 8; k++) begin
            term_hit[k] = (blk_ctl == (8'hFF << k)) && (blk_data[8*k +: 8] == XGMII_TERM);
            for (int j = k + 1; j < 8; j++)
                term_hit[k] = term_hit[k] && idle_lane[j];
            if (term_hit[k])
                t_lane = 3'(k);
        end
        if (err_lane != '0)
            kind = BLK_ERROR;
        else if (blk_ctl == 8'h00)
            kind = BLK_DATA;
        else if (blk_ctl == 8'hFF && idle_lane == 8'hFF)
            kind = BLK_IDLE;
        else if (blk_ctl == 8'h01 && blk_data[7:0] == XGMII_START)
            kind = BLK_START;
        else if (blk_ctl == 8'h1F && idle_lane[3:0] == 4'hF && blk_data[39:32] == XGMII_START) begin
            kind     = BLK_START;
            start_hi = 1'b1;
        end else if (term_hit != '0)
            kind = BLK_TERM;
    end

    assign term_mask = (64'h1 << {t_lane, 3'b000}) - 64'h1;

    always_comb begin
        emit       = kind;
        next_state = state;
        case (state)
            OUT_FRAME: begin
                if (kind == BLK_START)
                    next_state = IN_FRAME;
                else if (kind == BLK_DATA || kind == BLK_TERM)
                    emit = BLK_ERROR;
            end
            default: begin
                if (kind == BLK_TERM)
                    next_state = OUT_FRAME;
                else if (kind == BLK_IDLE) begin
                    emit       = BLK_ERROR;
                    next_state = OUT_FRAME;
                end else if (kind == BLK_START)
                    emit = BLK_ERROR;
            end
        endcase

        enc_header  = SYNC_CTRL;
        enc_payload = ERR_PAYLOAD;
        case (emit)
            BLK_DATA: begin
                enc_header  = SYNC_DATA;
                enc_payload = blk_data;
            end
            BLK_IDLE:  enc_payload = {{8{CC_IDLE}}, BT_IDLE};
            BLK_START: enc_payload = start_hi ?
                           {blk_data[63:40], {4{CC_IDLE}}, 4'h0, BT_START4} :
                           {blk_data[63:8], BT_START0};
            BLK_TERM:  enc_payload = ((blk_data & term_mask) << 8) | {56'h0, term_type(t_lane)};
            default:   enc_payload = ERR_PAYLOAD;
        endcase
    end

    pcs_scrambler #(
        .SCRAMBLER_SEED(SCRAMBLER_SEED)
    ) u_scrambler (
        .tx_clk   (tx_clk),
        .tx_rst   (tx_rst),
        .enable   (load),
        .plain    (enc_payload),
        .scrambled(scr_payload)
    );

    assign tx_payload = SCRAMBLER_BYPASS ? enc_payload : scr_payload;

    // Stage p1: output block register and frame state
    always_ff @(posedge tx_clk) begin
        if (!tx_rst) begin
            word_phase       <= 1'b0;
            state            <= OUT_FRAME;
            out_pcs_valid    <= 1'b0;
            out_pcs_data     <= '0;
            out_pcs_header   <= SYNC_CTRL;
            out_encode_error <= 1'b0;
        end else begin
            out_encode_error <= load && (emit == BLK_ERROR);
            if (out_xgmii_pcs_ready)
                word_phase <= ~word_phase;
            if (load) begin
                out_pcs_data   <= tx_payload;
                out_pcs_header <= enc_header;
                out_pcs_valid  <= 1'b1;
                state          <= next_state;
            end else if (in_pcs_ready) begin
                out_pcs_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_tx_pcs_encoder.sv
// Directed bench for tx_pcs_encoder: block vector table, back-pressured frame,
// reset mid-pair and scrambler golden value with descrambler loopback.
module tb_tx_pcs_encoder;

    logic        tx_clk;
    logic        tx_rst;
    logic [31:0] in_xgmii_data;
    logic [3:0]  in_xgmii_ctl;
    logic        in_xgmii_valid;
    logic        in_pcs_ready;
    logic        out_xgmii_pcs_ready;
    logic [63:0] out_pcs_data;
    logic [1:0]  out_pcs_header;
    logic        out_pcs_valid;
    logic        out_encode_error;
    logic        s_ready;
    logic [63:0] s_data;
    logic [1:0]  s_header;
    logic        s_valid;
    logic        s_error;

    tx_pcs_encoder #(.SCRAMBLER_BYPASS(1'b1)) dut (
        .tx_clk(tx_clk), .tx_rst(tx_rst),
        .in_xgmii_data(in_xgmii_data), .in_xgmii_ctl(in_xgmii_ctl),
        .in_xgmii_valid(in_xgmii_valid), .out_xgmii_pcs_ready(out_xgmii_pcs_ready),
        .out_pcs_data(out_pcs_data), .out_pcs_header(out_pcs_header),
        .out_pcs_valid(out_pcs_valid), .in_pcs_ready(in_pcs_ready),
        .out_encode_error(out_encode_error)
    );

    tx_pcs_encoder #(.SCRAMBLER_BYPASS(1'b0)) dut_scr (
        .tx_clk(tx_clk), .tx_rst(tx_rst),
        .in_xgmii_data(in_xgmii_data), .in_xgmii_ctl(in_xgmii_ctl),
        .in_xgmii_valid(in_xgmii_valid), .out_xgmii_pcs_ready(s_ready),
        .out_pcs_data(s_data), .out_pcs_header(s_header),
        .out_pcs_valid(s_valid), .in_pcs_ready(in_pcs_ready),
        .out_encode_error(s_error)
    );

    initial tx_clk = 1'b0;
    always #5 tx_clk = ~tx_clk;

    typedef struct {
        logic        v;
        logic [31:0] lo_d;
        logic [3:0]  lo_c;
        logic [31:0] hi_d;
        logic [3:0]  hi_c;
        logic [1:0]  hdr;
        logic [63:0] pay;
        logic        err;
    } vec_t;

    localparam logic [31:0] IDL     = 32'h07070707;
    localparam logic [31:0] JUNK    = 32'hDEADBEEF;
    localparam logic [31:0] S0_LO   = 32'h555555FB;
    localparam logic [31:0] S0_HI   = 32'hD5555555;
    localparam logic [31:0] S4_HI   = 32'hDDCCBBFB;
    localparam logic [31:0] A_LO    = 32'hA4A3A2A1;
    localparam logic [63:0] S0_PAY  = 64'hD555555555555578;
    localparam logic [63:0] S4_PAY  = 64'hDDCCBB0000000033;
    localparam logic [63:0] IDL_PAY = 64'h000000000000001E;
    localparam logic [63:0] ERR_PAY = 64'h3C78F1E3C78F1E1E;
    localparam logic [63:0] DAT_PAY = 64'h0807060504030201;
    localparam logic [63:0] SCR_IDLE_GOLD = 64'h7BFFF0800000001E;

    int          n_chk  = 0;
    int          n_pass = 0;
    vec_t        tbl[$];
    logic [57:0] ds;
    logic [31:0] fw_d[20];
    logic [3:0]  fw_c[20];
    logic [63:0] fe_p[10];
    logic [1:0]  fe_h[10];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    endtask

    task automatic drive(input logic v, input logic [31:0] d, input logic [3:0] c);
        in_xgmii_valid = v;
        in_xgmii_data  = d;
        in_xgmii_ctl   = c;
    endtask

    task automatic do_reset();
        tx_rst       = 1'b0;
        in_pcs_ready = 1'b1;
        drive(1'b0, JUNK, 4'h0);
        repeat (3) @(negedge tx_clk);
        tx_rst = 1'b1;
    endtask

    task automatic descramble(input logic [63:0] x, output logic [63:0] y);
        y = '0;
        for (int i = 0; i < 64; i++) begin
            y[i] = x[i] ^ ds[38] ^ ds[57];
            ds   = {ds[56:0], x[i]};
        end
    endtask

    function automatic vec_t mk(input logic v, input logic [31:0] ld, input logic [3:0] lc,
                                input logic [31:0] hd, input logic [3:0] hc,
                                input logic [1:0] h, input logic [63:0] p, input logic e);
        vec_t t;
        t.v = v; t.lo_d = ld; t.lo_c = lc; t.hi_d = hd; t.hi_c = hc;
        t.hdr = h; t.pay = p; t.err = e;
        return t;
    endfunction

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        logic [63:0] rec;
        int j, blk, cyc;

        // Vector table; FSM state after each entry noted on the right
        tbl.push_back(mk(0, JUNK, 4'h0, JUNK, 4'h0, 2'b10, IDL_PAY, 0));            // OUT
        tbl.push_back(mk(0, JUNK, 4'h0, JUNK, 4'h0, 2'b10, IDL_PAY, 0));            // OUT
        tbl.push_back(mk(1, S0_LO, 4'h1, S0_HI, 4'h0, 2'b10, S0_PAY, 0));           // IN
        tbl.push_back(mk(1, 32'h04030201, 4'h0, 32'h08070605, 4'h0, 2'b01, DAT_PAY, 0));
        tbl.push_back(mk(1, 32'h070707FD, 4'hF, IDL, 4'hF, 2'b10, 64'h87, 0));       // OUT
        tbl.push_back(mk(1, IDL, 4'hF, S4_HI, 4'h1, 2'b10, S4_PAY, 0));             // IN
        tbl.push_back(mk(1, 32'h0707FDA1, 4'hE, IDL, 4'hF, 2'b10, 64'hA199, 0));
        tbl.push_back(mk(1, S0_LO, 4'h1, S0_HI, 4'h0, 2'b10, S0_PAY, 0));
        tbl.push_back(mk(1, 32'h07FDA2A1, 4'hC, IDL, 4'hF, 2'b10, 64'hA2A1AA, 0));
        tbl.push_back(mk(1, IDL, 4'hF, S4_HI, 4'h1, 2'b10, S4_PAY, 0));
        tbl.push_back(mk(1, 32'hFDA3A2A1, 4'h8, IDL, 4'hF, 2'b10, 64'hA3A2A1B4, 0));
        tbl.push_back(mk(1, S0_LO, 4'h1, S0_HI, 4'h0, 2'b10, S0_PAY, 0));
        tbl.push_back(mk(1, A_LO, 4'h0, 32'h070707FD, 4'hF, 2'b10, 64'hA4A3A2A1CC, 0));
        tbl.push_back(mk(1, S0_LO, 4'h1, S0_HI, 4'h0, 2'b10, S0_PAY, 0));
        tbl.push_back(mk(1, A_LO, 4'h0, 32'h0707FDA5, 4'hE, 2'b10, 64'hA5A4A3A2A1D2, 0));
        tbl.push_back(mk(1, S0_LO, 4'h1, S0_HI, 4'h0, 2'b10, S0_PAY, 0));
        tbl.push_back(mk(1, A_LO, 4'h0, 32'h07FDA6A5, 4'hC, 2'b10, 64'hA6A5A4A3A2A1E1, 0));
        tbl.push_back(mk(1, S0_LO, 4'h1, S0_HI, 4'h0, 2'b10, S0_PAY, 0));
        tbl.push_back(mk(1, A_LO, 4'h0, 32'hFDA7A6A5, 4'h8, 2'b10, 64'hA7A6A5A4A3A2A1FF, 0)); // OUT
        tbl.push_back(mk(1, 32'h04030201, 4'h0, 32'h08070605, 4'h0, 2'b10, ERR_PAY, 1));   // data out of frame
        tbl.push_back(mk(1, 32'h070707FD, 4'hF, IDL, 4'hF, 2'b10, ERR_PAY, 1));            // term out of frame
        tbl.push_back(mk(1, 32'h07FE0707, 4'hF, IDL, 4'hF, 2'b10, ERR_PAY, 1));            // /E/ in lane 2
        tbl.push_back(mk(1, 32'h5555FB55, 4'h2, 32'h55555555, 4'h0, 2'b10, ERR_PAY, 1));   // /S/ in lane 1
        tbl.push_back(mk(1, S0_LO, 4'h1, S0_HI, 4'h0, 2'b10, S0_PAY, 0));                  // IN
        tbl.push_back(mk(1, S0_LO, 4'h1, S0_HI, 4'h0, 2'b10, ERR_PAY, 1));                 // start in frame, stay IN
        tbl.push_back(mk(1, 32'h04030201, 4'h0, 32'h08070605, 4'h0, 2'b01, DAT_PAY, 0));
        tbl.push_back(mk(1, IDL, 4'hF, IDL, 4'hF, 2'b10, ERR_PAY, 1));                     // idle in frame -> OUT
        tbl.push_back(mk(1, 32'h04030201, 4'h0, 32'h08070605, 4'h0, 2'b10, ERR_PAY, 1));
        tbl.push_back(mk(1, IDL, 4'hF, 32'h0707FE07, 4'hF, 2'b10, ERR_PAY, 1));            // /E/ in lane 5
        tbl.push_back(mk(0, JUNK, 4'h0, JUNK, 4'h0, 2'b10, IDL_PAY, 0));

        // 64-byte frame: start, eight data blocks, terminate in lane 0
        fw_d[0] = S0_LO; fw_c[0] = 4'h1;
        fw_d[1] = S0_HI; fw_c[1] = 4'h0;
        for (int k = 0; k < 16; k++) begin
            for (int m = 0; m < 4; m++) fw_d[2+k][8*m +: 8] = 8'(4*k + m);
            fw_c[2+k] = 4'h0;
        end
        fw_d[18] = 32'h070707FD; fw_c[18] = 4'hF;
        fw_d[19] = IDL;          fw_c[19] = 4'hF;
        fe_p[0] = S0_PAY; fe_h[0] = 2'b10;
        for (int b = 0; b < 8; b++) begin
            for (int m = 0; m < 8; m++) fe_p[1+b][8*m +: 8] = 8'(8*b + m);
            fe_h[1+b] = 2'b01;
        end
        fe_p[9] = 64'h87; fe_h[9] = 2'b10;

        // Reset values
        tx_rst = 1'b0;
        in_pcs_ready = 1'b1;
        drive(1'b0, JUNK, 4'h0);
        repeat (3) @(negedge tx_clk);
        chk("rst_valid",  out_pcs_valid, 1'b0);
        chk("rst_header", out_pcs_header, 2'b10);
        chk("rst_data",   out_pcs_data, 64'h0);
        chk("rst_error",  out_encode_error, 1'b0);
        chk("rst_ready",  out_xgmii_pcs_ready, 1'b1);
        tx_rst = 1'b1;

        // Table: pairs back-to-back with downstream always ready
        ds = '1;
        drive(tbl[0].v, tbl[0].lo_d, tbl[0].lo_c);
        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge tx_clk);
            chk($sformatf("tbl%0d_gap", i), {out_pcs_valid, out_encode_error}, 2'b00);
            drive(tbl[i].v, tbl[i].hi_d, tbl[i].hi_c);
            @(negedge tx_clk);
            chk($sformatf("tbl%0d_blk", i),
                {out_pcs_valid, out_pcs_header, out_pcs_data, out_encode_error},
                {1'b1, tbl[i].hdr, tbl[i].pay, tbl[i].err});
            if (i == 0)
                chk("scr_first_idle", s_data, SCR_IDLE_GOLD);
            descramble(s_data, rec);
            chk($sformatf("tbl%0d_descr", i), {s_valid, s_header, rec}, {1'b1, tbl[i].hdr, tbl[i].pay});
            if (i + 1 < tbl.size())
                drive(tbl[i+1].v, tbl[i+1].lo_d, tbl[i+1].lo_c);
            else
                drive(1'b0, JUNK, 4'h0);
        end

        // Full frame with a 5-cycle downstream stall while a block is pending
        do_reset();
        j = 0; blk = 0; cyc = 0;
        while (blk < 10 && cyc < 200) begin
            in_pcs_ready = !(cyc >= 4 && cyc < 9);
            if (j < 20) drive(1'b1, fw_d[j], fw_c[j]);
            else        drive(1'b0, JUNK, 4'h0);
            #1;
            if (out_pcs_valid) begin
                if (in_pcs_ready) begin
                    chk($sformatf("frame_blk%0d", blk), {out_pcs_header, out_pcs_data, out_encode_error},
                        {fe_h[blk], fe_p[blk], 1'b0});
                    blk++;
                end else begin
                    chk($sformatf("stall_c%0d", cyc), {out_xgmii_pcs_ready, out_pcs_header, out_pcs_data},
                        {1'b0, fe_h[blk], fe_p[blk]});
                end
            end
            if (out_xgmii_pcs_ready && j < 20) j++;
            @(negedge tx_clk);
            cyc++;
        end
        chk("frame_block_count", blk, 10);

        // Reset while a phase-0 word is held: it must be discarded
        do_reset();
        drive(1'b1, S0_LO, 4'h1);
        @(negedge tx_clk);
        tx_rst = 1'b0;
        drive(1'b1, A_LO, 4'h0);
        @(negedge tx_clk);
        @(negedge tx_clk);
        chk("midrst_outputs", {out_pcs_valid, out_xgmii_pcs_ready, out_encode_error}, 3'b010);
        tx_rst = 1'b1;
        drive(1'b1, IDL, 4'hF);
        @(negedge tx_clk);
        drive(1'b1, S4_HI, 4'h1);
        @(negedge tx_clk);
        chk("midrst_pair", {out_pcs_valid, out_pcs_header, out_pcs_data, out_encode_error},
            {1'b1, 2'b10, S4_PAY, 1'b0});
        drive(1'b0, JUNK, 4'h0);
        @(negedge tx_clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
